// File: rtl/line_buffer_ctrl_if.sv
// Bus between the 5x5 line-buffer controller, the pixel source, the six
// line buffers and the window consumer.
//
// Handshake: a window moves downstream in every cycle where o_window_valid
// and i_window_ready are both high at the rising clock edge. While valid is
// high and ready is low, o_window holds its value and no read pointer moves.
// Pixels have no back-pressure: i_pixel_valid is a one-cycle strobe.
// Overflow is reported on o_overflow, and o_intr signals that a row buffer has
// been freed.
interface line_buffer_ctrl_if #(
  parameter int PIX_W = 8,
  parameter int IMG_W = 32
);
  localparam int COL_W  = $clog2(IMG_W);
  localparam int FILL_W = $clog2(6 * IMG_W + 1);

  logic [PIX_W-1:0]    i_pixel_data;
  logic                i_pixel_valid;
  logic [PIX_W-1:0]    o_lb_data;
  logic [5:0]          o_lb_wr_en;
  logic [5:0]          o_lb_rd_en;
  logic [30*PIX_W-1:0] i_lb_rd_data;
  logic [25*PIX_W-1:0] o_window;
  logic                o_window_valid;
  logic                i_window_ready;
  logic                o_intr;
  logic                o_overflow;
  // Debug view of internal state.
  logic                o_dbg_state;
  logic [FILL_W-1:0]   o_dbg_fill_cnt;
  logic [2:0]          o_dbg_wr_buf;
  logic [COL_W-1:0]    o_dbg_wr_col;
  logic [2:0]          o_dbg_rd_buf;
  logic [COL_W-1:0]    o_dbg_rd_col;

  modport slave (
    input  i_pixel_data, i_pixel_valid, i_lb_rd_data, i_window_ready,
    output o_lb_data, o_lb_wr_en, o_lb_rd_en, o_window, o_window_valid,
    output o_intr, o_overflow,
    output o_dbg_state, o_dbg_fill_cnt, o_dbg_wr_buf, o_dbg_wr_col,
    output o_dbg_rd_buf, o_dbg_rd_col
  );

  modport master (
    output i_pixel_data, i_pixel_valid, i_lb_rd_data, i_window_ready,
    input  o_lb_data, o_lb_wr_en, o_lb_rd_en, o_window, o_window_valid,
    input  o_intr, o_overflow,
    input  o_dbg_state, o_dbg_fill_cnt, o_dbg_wr_buf, o_dbg_wr_col,
    input  o_dbg_rd_buf, o_dbg_rd_col
  );
endinterface

// File: rtl/line_buffer_ctrl.sv
// Sequences six line buffers for a 5x5 convolution window. Rows are written
// round-robin. Once five rows are resident, those rows are read in lock-step.
// The last four columns of each row are flush strobes that return the buffer
// read pointers to zero.
module line_buffer_ctrl #(
  parameter int IMG_W = 32,
  parameter int PIX_W = 8
) (
  input logic            i_clk,
  input logic            i_rst,
  line_buffer_ctrl_if.slave bus
);
  localparam int NBUF   = 6;
  localparam int K      = 5;
  localparam int ROW_W  = K * PIX_W;
  localparam int COL_W  = $clog2(IMG_W);
  localparam int FILL_W = $clog2(NBUF * IMG_W + 1);

  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(NBUF * IMG_W);
  localparam logic [FILL_W-1:0] FILL_READ = FILL_W'(K * IMG_W);
  localparam logic [FILL_W-1:0] FILL_ROW  = FILL_W'(IMG_W);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IMG_W - 1);
  localparam logic [COL_W-1:0]  COL_FLUSH = COL_W'(IMG_W - 4);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_READ = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [FILL_W-1:0]  fill_cnt_q, fill_cnt_d;
  logic [2:0]         wr_buf_q, wr_buf_d, rd_buf_q, rd_buf_d;
  logic [COL_W-1:0]   wr_col_q, wr_col_d, rd_col_q, rd_col_d;
  logic               intr_q, ovf_q;

  logic               full, wr_acc, adv, row_done, win_valid;
  logic [5:0]         wr_en, rd_en, active_mask;
  logic [25*PIX_W-1:0] window;
  logic [2:0]         idx;

  // Modulo-6 buffer index addition.
  function automatic logic [2:0] buf_add(input logic [2:0] b, input logic [2:0] k);
    logic [3:0] s;
    s = {1'b0, b} + {1'b0, k};
    if (s >= 4'd6) s = s - 4'd6;
    return s[2:0];
  endfunction

  // Write side: a one-hot enable and round-robin column and buffer pointers.
  // While reset is asserted, the enable is held low.
  always_comb begin
    full     = (fill_cnt_q == FILL_FULL);
    wr_acc   = bus.i_pixel_valid && !full && !i_rst;
    wr_en    = wr_acc ? (6'b000001 << wr_buf_q) : 6'b000000;
    wr_col_d = wr_col_q;
    wr_buf_d = wr_buf_q;
    if (wr_acc) begin
      if (wr_col_q == COL_LAST) begin
        wr_col_d = '0;
        wr_buf_d = buf_add(wr_buf_q, 3'd1);
      end else begin
        wr_col_d = wr_col_q + COL_W'(1);
      end
    end
  end

  // Read FSM: in IDLE, wait for five resident rows. In READ, walk one row.
  // The flush columns advance regardless of ready.
  always_comb begin
    state_d     = state_q;
    rd_col_d    = rd_col_q;
    rd_buf_d    = rd_buf_q;
    adv         = 1'b0;
    row_done    = 1'b0;
    win_valid   = 1'b0;
    rd_en       = 6'b000000;
    active_mask = ~(6'b000001 << buf_add(rd_buf_q, 3'd5)) & 6'b111111;
    case (state_q)
      S_IDLE: begin
        if (fill_cnt_q >= FILL_READ) state_d = S_READ;
      end
      S_READ: begin
        win_valid = (rd_col_q < COL_FLUSH);
        adv       = !win_valid || bus.i_window_ready;
        if (adv) begin
          rd_en = active_mask;
          if (rd_col_q == COL_LAST) begin
            row_done = 1'b1;
            rd_col_d = '0;
            rd_buf_d = buf_add(rd_buf_q, 3'd1);
            state_d  = S_IDLE;
          end else begin
            rd_col_d = rd_col_q + COL_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    fill_cnt_d = fill_cnt_q + FILL_W'(wr_acc) - (row_done ? FILL_ROW : FILL_W'(0));
  end

  // Window assembly: the oldest active row goes in the top slice. The window is zero when not valid.
  always_comb begin
    window = '0;
    idx    = '0;
    if (win_valid) begin
      for (int k = 0; k < K; k++) begin
        idx = buf_add(rd_buf_q, 3'(k));
        window[(K-1-k)*ROW_W +: ROW_W] = bus.i_lb_rd_data[int'(idx)*ROW_W +: ROW_W];
      end
    end
  end

  // State, pointers, fill count and registered event pulses.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      fill_cnt_q <= '0;
      wr_buf_q   <= '0;
      wr_col_q   <= '0;
      rd_buf_q   <= '0;
      rd_col_q   <= '0;
      intr_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
      wr_buf_q   <= wr_buf_d;
      wr_col_q   <= wr_col_d;
      rd_buf_q   <= rd_buf_d;
      rd_col_q   <= rd_col_d;
      intr_q     <= row_done;
      ovf_q      <= bus.i_pixel_valid && full;
    end
  end

  assign bus.o_lb_data      = bus.i_pixel_data;
  assign bus.o_lb_wr_en     = wr_en;
  assign bus.o_lb_rd_en     = rd_en;
  assign bus.o_window       = window;
  assign bus.o_window_valid = win_valid;
  assign bus.o_intr         = intr_q;
  assign bus.o_overflow     = ovf_q;
  assign bus.o_dbg_state    = (state_q == S_READ);
  assign bus.o_dbg_fill_cnt = fill_cnt_q;
  assign bus.o_dbg_wr_buf   = wr_buf_q;
  assign bus.o_dbg_wr_col   = wr_col_q;
  assign bus.o_dbg_rd_buf   = rd_buf_q;
  assign bus.o_dbg_rd_col   = rd_col_q;
endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Bench for line_buffer_ctrl. It uses behavioural models of the six line
// buffers, a window scoreboard, and directed row-stream scenarios.
module tb_line_buffer_ctrl;
  localparam int PIX_W = 8;
  localparam int IMG_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   intr_cnt = 0;
  logic [199:0] exp_q[$];

  always #5 clk = ~clk;

  line_buffer_ctrl_if #(.PIX_W(PIX_W), .IMG_W(IMG_W)) bus();

  line_buffer_ctrl #(.IMG_W(IMG_W), .PIX_W(PIX_W)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  // Line buffer models: a write pointer, a read pointer, and a five-pixel
  // combinational read port with the first pixel in the most significant byte.
  logic [7:0]   mem [6][32];
  logic [4:0]   wp [6];
  logic [4:0]   rp [6];
  logic [239:0] model_rd;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < 6; n++) begin
        wp[n] <= '0;
        rp[n] <= '0;
      end
    end else begin
      for (int n = 0; n < 6; n++) begin
        if (bus.o_lb_wr_en[n]) begin
          mem[n][wp[n]] <= bus.o_lb_data;
          wp[n] <= wp[n] + 5'd1;
        end
        if (bus.o_lb_rd_en[n]) rp[n] <= rp[n] + 5'd1;
      end
    end
  end

  always_comb begin
    model_rd = '0;
    for (int n = 0; n < 6; n++)
      for (int j = 0; j < 5; j++)
        model_rd[n*40 + (4-j)*8 +: 8] = mem[n][rp[n] + 5'(j)];
  end
  assign bus.i_lb_rd_data = model_rd;

  function automatic logic [199:0] exp_window(input int base_row, input int col);
    logic [199:0] w;
    w = '0;
    for (int k = 0; k < 5; k++)
      for (int j = 0; j < 5; j++)
        w[199 - 40*k - 8*j -: 8] = 8'((base_row + k) * 32 + col + j);
    return w;
  endfunction

  task automatic check(input string name, input logic [199:0] act, input logic [199:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.i_pixel_valid  = 1'b0;
    bus.i_window_ready = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic stream(input int count, input bit chk);
    for (int p = 0; p < count; p++) begin
      bus.i_pixel_valid = 1'b1;
      bus.i_pixel_data  = 8'(p);
      @(negedge clk);
      if (chk) check("wr_en_stream", bus.o_lb_wr_en, 6'b000001 << (p / 32));
      step();
    end
    bus.i_pixel_valid = 1'b0;
  endtask

  task automatic wait_read(output int lat);
    bit found;
    found = 0;
    lat = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (bus.o_window_valid) begin
        found = 1;
        lat = i;
      end else begin
        step();
      end
    end
    check("read_start", found, 1);
  endtask

  initial begin
    int lat, col, stalls, it, snap;
    bit adv;
    bus.i_pixel_data   = '0;
    bus.i_pixel_valid  = 1'b0;
    bus.i_window_ready = 1'b0;

    fork
      forever begin
        @(negedge clk);
        if (!rst && bus.o_intr) intr_cnt++;
        if (!rst && bus.o_window_valid && bus.i_window_ready) begin
          check("sb_window_pending", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) check("sb_window", bus.o_window, exp_q.pop_front());
        end
      end
    join_none

    // Reset values, with the pixel passthrough active during reset.
    #1 rst = 1'b1;
    #1;
    bus.i_pixel_data  = 8'hA5;
    bus.i_pixel_valid = 1'b1;
    #1;
    check("rst_wr_en", bus.o_lb_wr_en, 0);
    check("rst_rd_en", bus.o_lb_rd_en, 0);
    check("rst_valid", bus.o_window_valid, 0);
    check("rst_intr", bus.o_intr, 0);
    check("rst_ovf", bus.o_overflow, 0);
    check("rst_lb_data", bus.o_lb_data, 8'hA5);
    check("rst_fill", bus.o_dbg_fill_cnt, 0);
    check("rst_state", bus.o_dbg_state, 0);
    do_reset();

    // Five rows, one row read with a 3-cycle stall at col 10 and ready low during the flush.
    for (int c = 0; c < 28; c++) exp_q.push_back(exp_window(0, c));
    snap = intr_cnt;
    stream(160, 1);
    bus.i_window_ready = 1'b1;
    wait_read(lat);
    check("read_latency", lat, 1);
    col = 0; stalls = 0; it = 0;
    while (col < 32 && it < 50) begin
      adv = (col >= 28) || bus.i_window_ready;
      check("rd_en", bus.o_lb_rd_en, adv ? 6'b011111 : 6'b000000);
      check("win_valid", bus.o_window_valid, col < 28);
      if (col < 28 && !bus.i_window_ready) check("win_hold", bus.o_window, exp_window(0, col));
      if (adv) col++;
      it++;
      step();
      if (col == 10 && stalls < 3) begin
        bus.i_window_ready = 1'b0;
        stalls++;
      end else if (col >= 28) begin
        bus.i_window_ready = 1'b0;
      end else begin
        bus.i_window_ready = 1'b1;
      end
      @(negedge clk);
    end
    check("row_cols", col, 32);
    check("row_stalls", stalls, 3);
    check("row_cycles", it, 35);
    check("intr_pulse", bus.o_intr, 1);
    check("rd_buf_next", bus.o_dbg_rd_buf, 1);
    check("state_idle", bus.o_dbg_state, 0);
    check("fill_after_row", bus.o_dbg_fill_cnt, 128);
    step();
    @(negedge clk);
    check("intr_low", bus.o_intr, 0);
    check("intr_count", intr_cnt - snap, 1);
    check("sb_drained_b", exp_q.size(), 0);

    // A write in the row_done cycle while fillCnt is 160.
    do_reset();
    for (int c = 0; c < 28; c++) exp_q.push_back(exp_window(0, c));
    stream(160, 0);
    bus.i_window_ready = 1'b1;
    wait_read(lat);
    repeat (30) begin
      step();
      @(negedge clk);
    end
    step();
    bus.i_pixel_valid = 1'b1;
    bus.i_pixel_data  = 8'd160;
    @(negedge clk);
    check("rowdone_wr_en", bus.o_lb_wr_en, 6'b100000);
    check("rowdone_rd_en", bus.o_lb_rd_en, 6'b011111);
    step();
    bus.i_pixel_valid = 1'b0;
    @(negedge clk);
    check("rowdone_fill", bus.o_dbg_fill_cnt, 129);
    check("rowdone_rd_buf", bus.o_dbg_rd_buf, 1);
    check("rowdone_wr_buf", bus.o_dbg_wr_buf, 5);
    check("rowdone_wr_col", bus.o_dbg_wr_col, 1);
    check("rowdone_intr", bus.o_intr, 1);
    check("sb_drained_c", exp_q.size(), 0);

    // Fill all six buffers with ready low, then send one pixel too many.
    do_reset();
    stream(192, 1);
    bus.i_pixel_valid = 1'b1;
    bus.i_pixel_data  = 8'hEE;
    @(negedge clk);
    check("full_fill", bus.o_dbg_fill_cnt, 192);
    check("full_wr_en", bus.o_lb_wr_en, 0);
    check("full_rd_en", bus.o_lb_rd_en, 0);
    check("full_valid", bus.o_window_valid, 1);
    check("full_window", bus.o_window, exp_window(0, 0));
    step();
    bus.i_pixel_valid = 1'b0;
    @(negedge clk);
    check("ovf_pulse", bus.o_overflow, 1);
    check("ovf_fill", bus.o_dbg_fill_cnt, 192);
    check("ovf_wr_buf", bus.o_dbg_wr_buf, 0);
    check("ovf_wr_col", bus.o_dbg_wr_col, 0);
    step();
    @(negedge clk);
    check("ovf_low", bus.o_overflow, 0);

    // Assert reset asynchronously while the read is stalled in READ.
    bus.i_pixel_valid = 1'b1;
    bus.i_pixel_data  = 8'h3C;
    #2 rst = 1'b1;
    #1;
    check("arst_wr_en", bus.o_lb_wr_en, 0);
    check("arst_rd_en", bus.o_lb_rd_en, 0);
    check("arst_valid", bus.o_window_valid, 0);
    check("arst_intr", bus.o_intr, 0);
    check("arst_ovf", bus.o_overflow, 0);
    check("arst_state", bus.o_dbg_state, 0);
    check("arst_fill", bus.o_dbg_fill_cnt, 0);
    check("arst_lb_data", bus.o_lb_data, 8'h3C);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_wr_en", bus.o_lb_wr_en, 6'b000001);
    step();
    bus.i_pixel_valid = 1'b0;
    @(negedge clk);
    check("post_rst_wr_col", bus.o_dbg_wr_col, 1);
    check("post_rst_wr_buf", bus.o_dbg_wr_buf, 0);
    check("post_rst_fill", bus.o_dbg_fill_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
